// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// State encoding, latency-counter width and a byte-lane merge helper.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_RESP = ST_RESP
    } state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Word-addressed data SRAM: one array per byte lane, lane write mask and
// read-enabled registered read port. Contents are never reset.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic             re_i,
    input  logic [3:0]       be_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH_WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk_i) begin
                if (we_i && be_i[gi]) begin
                    mem_q[idx_i] <= wdata_i[8*gi +: 8];
                end
                if (re_i) begin
                    rd_q <= mem_q[idx_i];
                end
            end

            assign rdata_o[8*gi +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: request handshake, programmable
// latency, byte-enabled SRAM access and held response handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic             load_ok_q, load_ok_d;
    logic             busy_q, busy_d;
    logic             req_ready_q, req_ready_d;

    logic             from_idle;
    logic             commit;
    logic             c_write;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic             c_err;
    logic             sram_we;
    logic             sram_re;
    logic [31:0]      sram_rdata;

    // With LATENCY == 1 the commit edge is the accept edge, so the access
    // must be steered straight from the request inputs instead of the captures.
    assign from_idle = (state_q == S_IDLE);
    assign c_write   = from_idle ? req_write_i : write_q;
    assign c_addr    = from_idle ? req_addr_i  : addr_q;
    assign c_wdata   = from_idle ? req_wdata_i : wdata_q;
    assign c_be      = from_idle ? req_be_i    : be_q;
    assign c_err     = (c_addr[1:0] != 2'b00) ||
                       ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign commit = (from_idle && req_valid_i && (LATENCY == 1)) ||
                    ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));

    // Gated by reset so nothing reaches the array while reset is held.
    assign sram_we = commit && c_write && !c_err && rst_i;
    assign sram_re = commit && !c_write && !c_err && rst_i;

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk_i   (clk_i),
        .we_i    (sram_we),
        .re_i    (sram_re),
        .be_i    (c_be),
        .idx_i   (c_addr[IDX_W+1:2]),
        .wdata_i (c_wdata),
        .rdata_o (sram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        load_ok_d   = load_ok_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    be_d    = req_be_i;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d   = CNT_W'(LATENCY - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    load_ok_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = c_err;
            load_ok_d   = !c_write && !c_err;
        end

        busy_d      = (state_d != S_IDLE);
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            load_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            load_ok_q   <= load_ok_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
        end
    end

    // Read data only shows through for a successful load; stores and errors read 0.
    assign rsp_rdata_o = load_ok_q ? sram_rdata : 32'h0;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = busy_q;
    assign req_ready_o = req_ready_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=1,
// selected by sel, checked against a word-array reference model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;

    logic        a_req_ready, a_rsp_valid, a_err, a_busy;
    logic [31:0] a_rdata;
    logic        b_req_ready, b_rsp_valid, b_err, b_busy;
    logic [31:0] b_rdata;

    logic        o_req_ready, o_rsp_valid, o_err, o_busy;
    logic [31:0] o_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [256];
    bit          known     [256];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) u_dut_a (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid & ~sel),
        .req_ready_o (a_req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (a_rsp_valid),
        .rsp_ready_i (rsp_ready | sel),
        .rsp_rdata_o (a_rdata),
        .rsp_err_o   (a_err),
        .busy_o      (a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(1)) u_dut_b (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .req_valid_i (req_valid & sel),
        .req_ready_o (b_req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (b_rsp_valid),
        .rsp_ready_i (rsp_ready | ~sel),
        .rsp_rdata_o (b_rdata),
        .rsp_err_o   (b_err),
        .busy_o      (b_busy)
    );

    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_err       = sel ? b_err       : a_err;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_rdata     = sel ? b_rdata     : a_rdata;

    // Reference model: applies one transaction to the word array and returns what the DUT must answer.
    task automatic model_apply(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be, output logic [31:0] exp_rd,
                               output logic exp_err, output bit exp_known);
        logic [31:0] w;
        int          base;
        logic [31:0] mask;
        w         = addr >> 2;
        base      = sel ? 128 : 0;
        exp_err   = (addr % 4 != 0) || (w >= 128);
        exp_rd    = 32'h0;
        exp_known = 1'b1;
        if (!exp_err && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mask = 32'hFF << (8 * b);
                    model_mem[base + int'(w)] = (model_mem[base + int'(w)] & ~mask) | (wd & mask);
                end
            end
            if (be == 4'hF) known[base + int'(w)] = 1'b1;
        end else if (!exp_err) begin
            exp_rd    = model_mem[base + int'(w)];
            exp_known = known[base + int'(w)];
        end
    endtask

    // Drives one request from an idle, negedge-aligned point with rsp_ready high; returns observations.
    task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, output int edges, output logic [31:0] rd,
                       output logic er, output logic rdy_after);
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        edges     = 0;
        do begin
            @(negedge clk);
            edges++;
            req_valid = 1'b0;
        end while (o_rsp_valid !== 1'b1 && edges < 40);
        rd = o_rdata;
        er = o_err;
        @(negedge clk);
        rdy_after = o_req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            n_tests++;
            if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rdata !== 32'h0 ||
                o_err !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values sel=%0d: got rdy=%b vld=%b rd=%h err=%b busy=%b, want 1 0 0 0 0",
                         s, o_req_ready, o_rsp_valid, o_rdata, o_err, o_busy);
            end
        end
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset checked");
    endtask

    task automatic test_preload();
        int e; logic [31:0] rd, erd, wd; logic er, eer, ra; bit ek;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                model_apply(1'b1, 32'(w * 4), wd, 4'hF, erd, eer, ek);
                txn(1'b1, 32'(w * 4), wd, 4'hF, e, rd, er, ra);
                n_tests++;
                if (e != (s == 0 ? 2 : 1) || er !== 1'b0 || rd !== 32'h0) begin
                    n_fail++;
                    $display("FAIL preload_store sel=%0d w=%0d: got edges=%0d err=%b rd=%h, want %0d 0 0",
                             s, w, e, er, rd, (s == 0 ? 2 : 1));
                end
            end
        end
        sel = 1'b0;
        $display("[TB] preload done");
    endtask

    task automatic test_store_load();
        int e; logic [31:0] rd, erd; logic er, eer, ra; bit ek;
        model_apply(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer, ek);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, e, rd, er, ra);
        $display("[TB] store 0x10 edges=%0d err=%b rd=%h", e, er, rd);
        n_tests++;
        if (e != 2 || er !== 1'b0 || rd !== 32'h0 || ra !== 1'b1) begin
            n_fail++;
            $display("FAIL store_latency: got edges=%0d err=%b rd=%h rdy_after=%b, want 2 0 0 1", e, er, rd, ra);
        end
        model_apply(1'b0, 32'h10, 32'h0, 4'h0, erd, eer, ek);
        txn(1'b0, 32'h10, 32'h0, 4'h0, e, rd, er, ra);
        $display("[TB] load 0x10 rd=%h", rd);
        n_tests++;
        if (rd !== 32'hDEADBEEF || erd !== 32'hDEADBEEF || er !== 1'b0 || e != 2) begin
            n_fail++;
            $display("FAIL load_after_store: got rd=%h err=%b edges=%0d, want DEADBEEF 0 2", rd, er, e);
        end
    endtask

    task automatic test_byte_enable();
        int e; logic [31:0] rd, erd; logic er, eer, ra; bit ek;
        model_apply(1'b1, 32'h10, 32'h11223344, 4'b0101, erd, eer, ek);
        txn(1'b1, 32'h10, 32'h11223344, 4'b0101, e, rd, er, ra);
        txn(1'b0, 32'h10, 32'h0, 4'h0, e, rd, er, ra);
        $display("[TB] partial store then load 0x10 rd=%h", rd);
        n_tests++;
        if (rd !== 32'hDE22BE44) begin
            n_fail++;
            $display("FAIL byte_enable_merge: got %h, want DE22BE44", rd);
        end
        model_apply(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, erd, eer, ek);
        txn(1'b1, 32'h14, 32'hFFFFFFFF, 4'h0, e, rd, er, ra);
        n_tests++;
        if (er !== 1'b0 || e != 2) begin
            n_fail++;
            $display("FAIL be_zero_response: got err=%b edges=%0d, want 0 2", er, e);
        end
        model_apply(1'b0, 32'h14, 32'h0, 4'h0, erd, eer, ek);
        txn(1'b0, 32'h14, 32'h0, 4'h0, e, rd, er, ra);
        n_tests++;
        if (rd !== erd) begin
            n_fail++;
            $display("FAIL be_zero_no_write: got %h, want %h", rd, erd);
        end
    endtask

    task automatic test_errors();
        int e; logic [31:0] rd, erd; logic er, eer, ra; bit ek;
        txn(1'b0, 32'h12, 32'h0, 4'h0, e, rd, er, ra);
        $display("[TB] load 0x12 err=%b rd=%h edges=%0d", er, rd, e);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0 || e != 2) begin
            n_fail++;
            $display("FAIL misaligned_err: got err=%b rd=%h edges=%0d, want 1 0 2", er, rd, e);
        end
        model_apply(1'b1, 32'h200, 32'h55AA55AA, 4'hF, erd, eer, ek);
        txn(1'b1, 32'h200, 32'h55AA55AA, 4'hF, e, rd, er, ra);
        $display("[TB] store 0x200 err=%b edges=%0d", er, e);
        n_tests++;
        if (er !== 1'b1 || rd !== 32'h0 || e != 2) begin
            n_fail++;
            $display("FAIL range_err: got err=%b rd=%h edges=%0d, want 1 0 2", er, rd, e);
        end
        model_apply(1'b0, 32'h0, 32'h0, 4'h0, erd, eer, ek);
        txn(1'b0, 32'h0, 32'h0, 4'h0, e, rd, er, ra);
        n_tests++;
        if (rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL range_err_no_write: got rd=%h err=%b, want %h 0", rd, er, erd);
        end
    endtask

    task automatic test_backpressure();
        int n; logic [31:0] erd, snap_rd; logic eer, snap_err; bit ek;
        model_apply(1'b0, 32'h10, 32'h0, 4'h0, erd, eer, ek);
        rsp_ready = 1'b0;
        req_write = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            req_valid = 1'b0;
        end while (o_rsp_valid !== 1'b1 && n < 40);
        snap_rd  = o_rdata;
        snap_err = o_err;
        n_tests++;
        if (snap_rd !== erd || snap_err !== 1'b0 || n != 2) begin
            n_fail++;
            $display("FAIL bp_response: got rd=%h err=%b edges=%0d, want %h 0 2", snap_rd, snap_err, n, erd);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (o_rsp_valid !== 1'b1 || o_rdata !== snap_rd || o_err !== snap_err ||
                o_req_ready !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: got vld=%b rd=%h err=%b rdy=%b busy=%b, want 1 %h %b 0 1",
                         c, o_rsp_valid, o_rdata, o_err, o_req_ready, o_busy, snap_rd, snap_err);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        $display("[TB] backpressure released rdy=%b vld=%b", o_req_ready, o_rsp_valid);
        n_tests++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b vld=%b busy=%b, want 1 0 0", o_req_ready, o_rsp_valid, o_busy);
        end
    endtask

    task automatic test_reset_in_wait();
        int e; logic [31:0] rd, erd; logic er, eer, ra; bit ek;
        req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rdata !== 32'h0 ||
            o_err !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b vld=%b rd=%h err=%b busy=%b, want 1 0 0 0 0",
                     o_req_ready, o_rsp_valid, o_rdata, o_err, o_busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_apply(1'b0, 32'h20, 32'h0, 4'h0, erd, eer, ek);
        txn(1'b0, 32'h20, 32'h0, 4'h0, e, rd, er, ra);
        $display("[TB] after reset load 0x20 rd=%h", rd);
        n_tests++;
        if (rd !== erd || er !== 1'b0) begin
            n_fail++;
            $display("FAIL dropped_store: got rd=%h err=%b, want %h 0", rd, er, erd);
        end
    endtask

    task automatic test_back_to_back();
        int last_acc, done, issued, c; bit accepting;
        logic [31:0] addrs [6];
        logic [31:0] exp_q [$];
        logic [31:0] erd; logic eer; bit ek;
        sel = 1'b1;
        for (int i = 0; i < 6; i++) addrs[i] = 32'($urandom_range(0, 15) * 4);
        last_acc = -1; done = 0; issued = 0;
        rsp_ready = 1'b1; req_write = 1'b0; req_be = 4'h0;
        req_addr = addrs[0]; req_valid = 1'b1;
        for (c = 0; c < 40 && done < 6; c++) begin
            accepting = (o_req_ready === 1'b1) && (issued < 6);
            @(negedge clk);
            if (accepting) begin
                if (last_acc >= 0) begin
                    n_tests++;
                    if (c - last_acc != 2) begin
                        n_fail++;
                        $display("FAIL b2b_accept_gap: got %0d, want 2", c - last_acc);
                    end
                end
                last_acc = c;
                model_apply(1'b0, req_addr, 32'h0, 4'h0, erd, eer, ek);
                exp_q.push_back(erd);
                issued++;
                if (issued < 6) req_addr = addrs[issued];
                else req_valid = 1'b0;
            end
            n_tests++;
            if (o_busy !== o_rsp_valid) begin
                n_fail++;
                $display("FAIL b2b_busy cycle %0d: got busy=%b, want %b", c, o_busy, o_rsp_valid);
            end
            if (o_rsp_valid === 1'b1) begin
                erd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                $display("[TB] b2b response %0d rd=%h", done, o_rdata);
                n_tests++;
                if (last_acc != c || o_rdata !== erd || o_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_response %0d: got rd=%h err=%b acc_cycle=%0d now=%0d, want %h 0 same cycle",
                             done, o_rdata, o_err, last_acc, c, erd);
                end
                done++;
            end
        end
        req_valid = 1'b0;
        n_tests++;
        if (done != 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, want 6", done);
        end
        @(negedge clk);
        sel = 1'b0;
    endtask

    task automatic test_random();
        int e, pick; logic [31:0] rd, erd, addr, wd; logic er, eer, ra; logic [3:0] be; bit wr, ek;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 30; i++) begin
                pick = $urandom_range(0, 9);
                if (pick < 7)       addr = 32'($urandom_range(0, 20) * 4);
                else if (pick == 7) addr = 32'($urandom_range(0, 20) * 4 + $urandom_range(1, 3));
                else if (pick == 8) addr = 32'((128 + $urandom_range(0, 1000)) * 4);
                else                addr = $urandom & 32'hFFFF_FFFC;
                wr = $urandom_range(0, 1) == 1;
                wd = $urandom;
                be = 4'($urandom_range(0, 15));
                model_apply(wr, addr, wd, be, erd, eer, ek);
                txn(wr, addr, wd, be, e, rd, er, ra);
                $display("[TB] rand sel=%0d %s addr=%h be=%h rd=%h err=%b", s, wr ? "ST" : "LD", addr, be, rd, er);
                n_tests++;
                if (e != (s == 0 ? 2 : 1) || er !== eer || (ek && rd !== erd) || ra !== 1'b1) begin
                    n_fail++;
                    $display("FAIL random sel=%0d addr=%h: got edges=%0d err=%b rd=%h rdy=%b, want %0d %b %h 1",
                             s, addr, e, er, rd, ra, (s == 0 ? 2 : 1), eer, erd);
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; rsp_ready = 1'b1;
        req_addr = '0; req_wdata = '0; req_be = '0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 32'h0;
            known[i]     = 1'b0;
        end
        test_reset();
        test_preload();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
